// File: rtl/serial_tx.sv
// serial_tx: start/data(LSB first)/stop frame transmitter, each bit held DIV clocks.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             V,
  output logic             RDY,
  output logic             Q,
  output logic             BSY
);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  logic par;
`endif
  logic [2:0] state;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic bit_end;
  assign bit_end = tmr == TW'(DIV - 1);
  always_ff @(posedge C or posedge R)
    if (R) begin
      state <= IDLE;
      shift <= '0;
      cnt <= '0;
      tmr <= '0;
      Q <= 1'b1;
      RDY <= 1'b1;
      BSY <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (V) begin
        shift <= D;
        Q <= 1'b0;
        RDY <= 1'b0;
        BSY <= 1'b1;
        tmr <= '0;
        state <= START;
`ifdef SERIAL_TX_PARITY_EN
        par <= ^D;
`endif
      end
    end else if (!bit_end) begin
      tmr <= tmr + 1'b1;
    end else begin
      tmr <= '0;
      if (state == START) begin
        Q <= shift[0];
        shift <= shift >> 1;
        cnt <= '0;
        state <= DATA;
      end else if (state == DATA && cnt != CW'(WIDTH - 1)) begin
        Q <= shift[0];
        shift <= shift >> 1;
        cnt <= cnt + 1'b1;
      end else if (state == DATA) begin
`ifdef SERIAL_TX_PARITY_EN
        Q <= par;
        state <= PARITY;
`else
        Q <= 1'b1;
        state <= STOP;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      else if (state == PARITY) begin
        Q <= 1'b1;
        state <= STOP;
      end
`endif
      else begin
        state <= IDLE;
        RDY <= 1'b1;
        BSY <= 1'b0;
      end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed frame checks on a DIV=4 and a DIV=1 instance of serial_tx.
module tb_serial_tx;
  logic C = 1'b0;
  logic R = 1'b1;
  logic [7:0] D = '0;
  logic V = 1'b0;
  logic V1 = 1'b0;
  logic RDY, Q, BSY, RDY1, Q1, BSY1;
  int n_vec = 0;
  int n_bad = 0;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  serial_tx #(.WIDTH(8), .DIV(4)) dut (.C(C), .R(R), .D(D), .V(V), .RDY(RDY), .Q(Q), .BSY(BSY));
  serial_tx #(.WIDTH(8), .DIV(1)) dut1 (.C(C), .R(R), .D(D), .V(V1), .RDY(RDY1), .Q(Q1), .BSY(BSY1));

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame bits in time order: start, data LSB first, (parity), stop.
  function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  task automatic start(input logic sel, input logic [7:0] d);
    @(negedge C);
    D = d;
    if (sel) V1 = 1'b1; else V = 1'b1;
    @(posedge C);
  endtask

  // Called just after the accept edge; checks every clock of the frame, then the idle clock.
  task automatic watch(input logic sel, input logic [10:0] f);
    int div;
    div = sel ? 1 : 4;
    for (int i = 0; i < NB * div; i++) begin
      @(negedge C);
      chk("q", sel ? Q1 : Q, f[i / div]);
      chk("rdy_low", sel ? RDY1 : RDY, 0);
      chk("bsy_high", sel ? BSY1 : BSY, 1);
    end
    @(negedge C);
    chk("end_rdy", sel ? RDY1 : RDY, 1);
    chk("end_q", sel ? Q1 : Q, 1);
    chk("end_bsy", sel ? BSY1 : BSY, 0);
  endtask

  initial begin
    repeat (2) @(posedge C);
    @(negedge C);
    chk("reset", {Q, RDY, BSY}, 3'b110);
    R = 1'b0;
    repeat (20) begin
      @(negedge C);
      chk("idle", {Q, RDY, BSY}, 3'b110);
    end
    // Single frame A5
    start(0, 8'hA5);
    fork
      watch(0, frame(8'hA5));
      begin @(negedge C); V = 1'b0; D = 8'h00; end
    join
    // Busy rejection: FF presented mid-frame must never be sent
    start(0, 8'h3C);
    fork
      watch(0, frame(8'h3C));
      begin
        @(negedge C);
        V = 1'b0;
        repeat (9) @(negedge C);
        D = 8'hFF;
        V = 1'b1;
        repeat (5) @(negedge C);
        V = 1'b0;
      end
    join
    repeat (3) begin
      @(negedge C);
      chk("no_queue", {Q, RDY, BSY}, 3'b110);
    end
    // Back-to-back: 80 starts exactly one idle clock after the 01 frame
    start(0, 8'h01);
    fork
      watch(0, frame(8'h01));
      begin @(negedge C); D = 8'h80; end
    join
    @(posedge C);
    fork
      watch(0, frame(8'h80));
      begin @(negedge C); V = 1'b0; end
    join
    // Reset mid-frame aborts immediately
    start(0, 8'h00);
    @(negedge C);
    V = 1'b0;
    chk("pre_abort_q", Q, 0);
    repeat (12) @(posedge C);
    #2 R = 1'b1;
    #1 chk("abort", {Q, RDY, BSY}, 3'b110);
    @(negedge C);
    R = 1'b0;
    @(negedge C);
    chk("post_abort", {Q, RDY, BSY}, 3'b110);
    start(0, 8'h55);
    fork
      watch(0, frame(8'h55));
      begin @(negedge C); V = 1'b0; end
    join
    // DIV=1 instance
    start(1, 8'hA5);
    fork
      watch(1, frame(8'hA5));
      begin @(negedge C); V1 = 1'b0; end
    join
    start(1, 8'h07);
    fork
      watch(1, frame(8'h07));
      begin @(negedge C); V1 = 1'b0; end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
